// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: issue-side coordinates and markers, plus
// sync/DE/colour delayed through a tick-qualified pipeline to meet renderer colour.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned H_SYNC_POL = 0,
  parameter int unsigned V_SYNC_POL = 0,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned PIPE_DELAY = 1,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW        = $clog2(H_TOTAL),
  localparam int unsigned YW        = $clog2(V_TOTAL),
  localparam int unsigned CW        = 3 * COLOR_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pix_en,
  input  logic [CW-1:0]         i_color,
  output logic [XW-1:0]         o_coord_x,
  output logic [YW-1:0]         o_coord_y,
  output logic                  o_active,
  output logic                  o_line_start,
  output logic                  o_frame_start,
  output logic                  o_h_sync,
  output logic                  o_v_sync,
  output logic                  o_de,
  output logic [COLOR_BITS-1:0] o_vga_r,
  output logic [COLOR_BITS-1:0] o_vga_g,
  output logic [COLOR_BITS-1:0] o_vga_b
);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_VIS  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ON  = 1'(H_SYNC_POL);
  localparam logic          VS_ON  = 1'(V_SYNC_POL);
  localparam int unsigned   TW     = 3;

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic [TW-1:0] raw_c, dly_c;
  logic          de_q, de_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic [CW-1:0] rgb_q, rgb_d;

  // Raster counters
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (i_pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + YW'(1);
      end else begin
        h_cnt_d = h_cnt_q + XW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign o_coord_x     = h_cnt_q;
  assign o_coord_y     = v_cnt_q;
  assign o_active      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign o_line_start  = i_pix_en && (h_cnt_q == '0);
  assign o_frame_start = i_pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);

  // Undelayed timing bits, packed {de, hs, vs}, active-high regardless of pin polarity
  assign raw_c = {o_active,
                  (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END),
                  (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END)};

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign dly_c = raw_c;
    end else begin : g_pipe
      logic [TW-1:0] pipe_q [PIPE_DELAY];
      logic [TW-1:0] pipe_d [PIPE_DELAY];

      always_comb begin
        for (int i = 0; i < int'(PIPE_DELAY); i++) pipe_d[i] = pipe_q[i];
        if (i_pix_en) begin
          pipe_d[0] = raw_c;
          for (int i = 1; i < int'(PIPE_DELAY); i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < int'(PIPE_DELAY); i++) pipe_q[i] <= '0;
        end else begin
          for (int i = 0; i < int'(PIPE_DELAY); i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign dly_c = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  // Pin register: colour is blanked whenever the delayed DE is low
  always_comb begin
    de_d     = de_q;
    h_sync_d = h_sync_q;
    v_sync_d = v_sync_q;
    rgb_d    = rgb_q;
    if (i_pix_en) begin
      de_d     = dly_c[2];
      h_sync_d = dly_c[1] ? HS_ON : ~HS_ON;
      v_sync_d = dly_c[0] ? VS_ON : ~VS_ON;
      rgb_d    = dly_c[2] ? i_color : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_q     <= 1'b0;
      h_sync_q <= ~HS_ON;
      v_sync_q <= ~VS_ON;
      rgb_q    <= '0;
    end else begin
      de_q     <= de_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      rgb_q    <= rgb_d;
    end
  end

  assign o_de     = de_q;
  assign o_h_sync = h_sync_q;
  assign o_v_sync = v_sync_q;
  assign o_vga_r  = rgb_q[CW-1 -: COLOR_BITS];
  assign o_vga_g  = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign o_vga_b  = rgb_q[COLOR_BITS-1:0];

endmodule
